// File: rtl/pn_seq_tx.sv
// PN-8 transmit source: m-sequence x^8+x^6+x^5+x^4+1 at a programmable bit rate,
// presented as a logic bit and as a slew-limited bipolar DAC sample stream.
module pn_seq_tx #(
    parameter int unsigned        DIV_W = 16,
    parameter logic signed [11:0] AMP   = 12'sd1024,
    parameter logic        [11:0] STEP  = 12'd64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic        [7:0]        seed_i,
    input  logic        [DIV_W-1:0]  div_i,
    output logic                     bit_out_o,
    output logic                     bit_strobe_o,
    output logic                     frame_start_o,
    output logic signed [11:0]       dac_out_o
);

    localparam logic signed [12:0] AMP_P   = 13'(AMP);
    localparam logic signed [12:0] STEP_S  = $signed({1'b0, STEP});
    localparam logic signed [11:0] STEP_12 = $signed(STEP);
    localparam logic [7:0]         IDX_LAST = 8'd254;

    logic [7:0]         lfsr_q,   lfsr_d;
    logic [DIV_W-1:0]   cnt_q,    cnt_d;
    logic [7:0]         idx_q,    idx_d;
    logic               bit_q,    bit_d;
    logic               strobe_q, strobe_d;
    logic               frame_q,  frame_d;
    logic signed [11:0] dac_q,    dac_d;

    logic [DIV_W-1:0]   div_eff;
    logic               boundary;
    logic [7:0]         lfsr_next;
    logic signed [11:0] target;
    logic signed [12:0] diff;
    logic signed [11:0] ramp_next;

    assign div_eff   = (div_i == '0) ? DIV_W'(1) : div_i;
    // >= so that lowering div below the running count ends the symbol at once
    assign boundary  = (cnt_q >= div_eff);
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[1]};

    // Target and step both fit in 12 bits, so the wrap-around add/sub is exact.
    assign target = bit_q ? AMP : -AMP;
    assign diff   = 13'(target) - 13'(dac_q);

    always_comb begin
        ramp_next = target;
        if (diff > STEP_S) begin
            ramp_next = dac_q + STEP_12;
        end else if (diff < -STEP_S) begin
            ramp_next = dac_q - STEP_12;
        end
    end

    always_comb begin
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        dac_d    = dac_q;
        strobe_d = 1'b0;
        frame_d  = 1'b0;
        if (load_i) begin
            lfsr_d = (seed_i == 8'h00) ? 8'h01 : seed_i;
            cnt_d  = '0;
            idx_d  = 8'd0;
        end else if (en_i) begin
            dac_d = ramp_next;
            if (boundary) begin
                cnt_d    = '0;
                bit_d    = lfsr_q[7];
                lfsr_d   = lfsr_next;
                strobe_d = 1'b1;
                frame_d  = (idx_q == 8'd0);
                idx_d    = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q   <= 8'hFF;
            cnt_q    <= '0;
            idx_q    <= 8'd0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
            dac_q    <= 12'sd0;
        end else begin
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            dac_q    <= dac_d;
        end
    end

    assign bit_out_o     = bit_q;
    assign bit_strobe_o  = strobe_q;
    assign frame_start_o = frame_q;
    assign dac_out_o     = dac_q;

endmodule

// File: tb/tb_pn_seq_tx.sv
// Directed bench for pn_seq_tx: sequence statistics, seeding, framing, divider
// corner cases, enable gaps, DAC ramp and asynchronous reset.
module tb_pn_seq_tx;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               en_i;
    logic               load_i;
    logic [7:0]         seed_i;
    logic [15:0]        div_i;
    logic               bit_out_o;
    logic               bit_strobe_o;
    logic               frame_start_o;
    logic signed [11:0] dac_out_o;

    int errors = 0;
    int checks = 0;

    pn_seq_tx #(.DIV_W(16), .AMP(12'sd1024), .STEP(12'd64)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .load_i        (load_i),
        .seed_i        (seed_i),
        .div_i         (div_i),
        .bit_out_o     (bit_out_o),
        .bit_strobe_o  (bit_strobe_o),
        .frame_start_o (frame_start_o),
        .dac_out_o     (dac_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_strobe(input int budget, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            step();
            cyc++;
            if (bit_strobe_o === 1'b1) got = 1'b1;
        end
    endtask

    task automatic do_load(input logic [7:0] seed);
        seed_i = seed;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 1'b0; load_i = 1'b0; seed_i = 8'h00; div_i = 16'd3;
        #12;
        checks++; if (bit_out_o !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b want 0", bit_out_o); end
        checks++; if (bit_strobe_o !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bit_strobe_o); end
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame_start_o); end
        checks++; if (dac_out_o !== 12'sd0) begin errors++; $display("FAIL reset_dac: got %0d want 0", dac_out_o); end
    endtask

    task automatic test_sequence();
        logic bits [0:510];
        logic fs   [0:510];
        int cyc, per_err, tmo, ones, r1, r0, m1, m0, fs_other, rep_err;
        bit got;
        per_err = 0; tmo = 0;
        step();
        rst_ni = 1'b1; en_i = 1'b1; div_i = 16'd3;
        wait_strobe(20, cyc, got);
        checks++; if (!got || cyc != 4) begin errors++; $display("FAIL first_strobe: got %0d cycles want 4", cyc); end
        bits[0] = bit_out_o; fs[0] = frame_start_o;
        for (int n = 1; n < 511; n++) begin
            wait_strobe(20, cyc, got);
            if (!got) tmo++;
            if (cyc != 4) per_err++;
            bits[n] = bit_out_o; fs[n] = frame_start_o;
        end
        checks++; if (tmo != 0 || per_err != 0) begin errors++; $display("FAIL strobe_period: %0d bad periods %0d timeouts want 0", per_err, tmo); end
        checks++; if ({bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6], bits[7]} !== 8'hFF)
            begin errors++; $display("FAIL first_eight: got %b%b%b%b%b%b%b%b want 11111111", bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6], bits[7]); end
        ones = 0; r1 = 0; r0 = 0; m1 = 0; m0 = 0;
        for (int i = 0; i < 255; i++) begin
            if (bits[i] === 1'b1) begin ones++; r1++; r0 = 0; end
            else begin r0++; r1 = 0; end
            if (r1 > m1) m1 = r1;
            if (r0 > m0) m0 = r0;
        end
        checks++; if (ones != 128) begin errors++; $display("FAIL ones_count: got %0d want 128", ones); end
        checks++; if (m1 != 8) begin errors++; $display("FAIL run_ones: got %0d want 8", m1); end
        checks++; if (m0 != 7) begin errors++; $display("FAIL run_zeros: got %0d want 7", m0); end
        checks++; if (bits[255] !== bits[0]) begin errors++; $display("FAIL sym256: got %b want %b", bits[255], bits[0]); end
        rep_err = 0;
        for (int i = 0; i < 255; i++) if (bits[i + 255] !== bits[i]) rep_err++;
        checks++; if (rep_err != 0) begin errors++; $display("FAIL period_255: %0d differing symbols want 0", rep_err); end
        checks++; if (fs[0] !== 1'b1) begin errors++; $display("FAIL frame_1: got %b want 1", fs[0]); end
        checks++; if (fs[255] !== 1'b1) begin errors++; $display("FAIL frame_256: got %b want 1", fs[255]); end
        checks++; if (fs[510] !== 1'b1) begin errors++; $display("FAIL frame_511: got %b want 1", fs[510]); end
        fs_other = 0;
        for (int i = 0; i < 511; i++) if (i != 0 && i != 255 && i != 510 && fs[i] !== 1'b0) fs_other++;
        checks++; if (fs_other != 0) begin errors++; $display("FAIL frame_other: %0d extra pulses want 0", fs_other); end
    endtask

    task automatic test_seed_zero();
        logic [15:0] v0, v1;
        int cyc, first_cyc, tmo;
        bit got;
        tmo = 0;
        div_i = 16'd3;
        do_load(8'h00);
        v0 = '0;
        for (int n = 0; n < 16; n++) begin
            wait_strobe(20, cyc, got);
            if (n == 0) first_cyc = cyc;
            if (!got) tmo++;
            v0 = {v0[14:0], bit_out_o};
        end
        checks++; if (tmo != 0 || first_cyc != 4) begin errors++; $display("FAIL load_first_strobe: got %0d cycles want 4", first_cyc); end
        do_load(8'h01);
        v1 = '0;
        for (int n = 0; n < 16; n++) begin
            wait_strobe(20, cyc, got);
            if (!got) tmo++;
            v1 = {v1[14:0], bit_out_o};
        end
        checks++; if (tmo != 0 || v1[15:8] !== 8'h01) begin errors++; $display("FAIL seed01_bits: got %h want 01", v1[15:8]); end
        checks++; if (v0 !== v1) begin errors++; $display("FAIL seed00_vs_01: got %h want %h", v0, v1); end
    endtask

    task automatic test_load_boundary();
        int cyc;
        bit got;
        div_i = 16'd3;
        wait_strobe(20, cyc, got);
        step(); step(); step();
        seed_i = 8'hA5; load_i = 1'b1;
        step();
        load_i = 1'b0;
        checks++; if (!got || bit_strobe_o !== 1'b0) begin errors++; $display("FAIL load_beats_boundary: strobe %b want 0", bit_strobe_o); end
        wait_strobe(20, cyc, got);
        checks++; if (!got || cyc != 4 || bit_out_o !== 1'b1 || frame_start_o !== 1'b1)
            begin errors++; $display("FAIL post_load_symbol: cyc %0d bit %b frame %b want 4 1 1", cyc, bit_out_o, frame_start_o); end
    endtask

    task automatic test_div_edges();
        int cyc;
        bit got;
        div_i = 16'd0;
        wait_strobe(20, cyc, got);
        wait_strobe(20, cyc, got);
        checks++; if (!got || cyc != 2) begin errors++; $display("FAIL div0_period: got %0d want 2", cyc); end
        div_i = 16'd9;
        wait_strobe(20, cyc, got);
        wait_strobe(20, cyc, got);
        checks++; if (!got || cyc != 10) begin errors++; $display("FAIL div9_period: got %0d want 10", cyc); end
        for (int i = 0; i < 6; i++) step();
        div_i = 16'd2;
        step();
        checks++; if (bit_strobe_o !== 1'b1) begin errors++; $display("FAIL div_lowered: strobe %b want 1", bit_strobe_o); end
    endtask

    task automatic test_en_gap();
        int cyc, tmo, gap_strobes, gap_moves;
        bit got;
        logic [4:0] tail;
        logic signed [11:0] dac_hold;
        logic bit_hold;
        tmo = 0;
        div_i = 16'd9;
        do_load(8'hA5);
        for (int n = 0; n < 3; n++) begin
            wait_strobe(20, cyc, got);
            if (!got) tmo++;
        end
        step(); step(); step();
        dac_hold = dac_out_o; bit_hold = bit_out_o;
        en_i = 1'b0;
        gap_strobes = 0; gap_moves = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bit_strobe_o !== 1'b0) gap_strobes++;
            if (dac_out_o !== dac_hold || bit_out_o !== bit_hold) gap_moves++;
        end
        en_i = 1'b1;
        checks++; if (gap_strobes != 0) begin errors++; $display("FAIL gap_strobes: got %0d want 0", gap_strobes); end
        checks++; if (gap_moves != 0) begin errors++; $display("FAIL gap_hold: %0d cycles moved want 0", gap_moves); end
        wait_strobe(30, cyc, got);
        checks++; if (!got || 13 + cyc != 20) begin errors++; $display("FAIL gap_period: got %0d want 20", 13 + cyc); end
        tail = {bit_out_o, 4'b0000};
        for (int n = 1; n < 5; n++) begin
            wait_strobe(20, cyc, got);
            if (!got) tmo++;
            tail = {tail[3:0], bit_out_o};
        end
        tail = {tail[0], tail[4:1]} ^ {tail[0], tail[4:1]} ^ tail;
        checks++; if (tmo != 0 || tail !== 5'b00101) begin errors++; $display("FAIL gap_sequence: got %b want 00101", tail); end
    endtask

    task automatic test_ramp();
        int cyc, tmo, bad;
        bit got;
        logic prev;
        tmo = 0; bad = 0;
        div_i = 16'd99;
        do_load(8'h01);
        prev = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n == 7) prev = bit_out_o;
            wait_strobe(120, cyc, got);
            if (!got) tmo++;
        end
        checks++; if (tmo != 0 || prev !== 1'b0 || bit_out_o !== 1'b1) begin errors++; $display("FAIL ramp_edge: prev %b bit %b want 0 1", prev, bit_out_o); end
        checks++; if (dac_out_o !== -12'sd1024) begin errors++; $display("FAIL ramp_start: got %0d want -1024", dac_out_o); end
        for (int k = 1; k <= 32; k++) begin
            step();
            if (dac_out_o !== 12'(-1024 + 64 * k)) begin
                bad++;
                if (bad == 1) $display("FAIL ramp_step%0d: got %0d want %0d", k, dac_out_o, -1024 + 64 * k);
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ramp_steps: %0d wrong samples want 0", bad); end
        step();
        checks++; if (dac_out_o !== 12'sd1024) begin errors++; $display("FAIL ramp_hold: got %0d want 1024", dac_out_o); end
    endtask

    task automatic test_async_reset();
        int cyc, tmo, ones;
        bit got;
        tmo = 0;
        div_i = 16'd49;
        do_load(8'h01);
        for (int n = 0; n < 8; n++) begin
            wait_strobe(60, cyc, got);
            if (!got) tmo++;
        end
        for (int i = 0; i < 10; i++) step();
        checks++; if (tmo != 0 || dac_out_o !== -12'sd384) begin errors++; $display("FAIL mid_ramp: got %0d want -384", dac_out_o); end
        #3;
        rst_ni = 1'b0;
        #1;
        checks++; if (dac_out_o !== 12'sd0 || bit_out_o !== 1'b0 || bit_strobe_o !== 1'b0)
            begin errors++; $display("FAIL async_reset: dac %0d bit %b strobe %b want 0 0 0", dac_out_o, bit_out_o, bit_strobe_o); end
        #2;
        rst_ni = 1'b1;
        div_i = 16'd3;
        wait_strobe(20, cyc, got);
        checks++; if (!got || cyc != 4 || frame_start_o !== 1'b1) begin errors++; $display("FAIL restart_strobe: cyc %0d frame %b want 4 1", cyc, frame_start_o); end
        ones = (bit_out_o === 1'b1) ? 1 : 0;
        for (int n = 1; n < 8; n++) begin
            wait_strobe(20, cyc, got);
            if (!got) tmo++;
            if (bit_out_o === 1'b1) ones++;
        end
        checks++; if (tmo != 0 || ones != 8) begin errors++; $display("FAIL restart_bits: got %0d ones want 8", ones); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_seed_zero();
        test_load_boundary();
        test_div_edges();
        test_en_gap();
        test_ramp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pn_seq_tx.md
# pn_seq_tx

Transmit-side source for the digital transmission link: generates the 8th-order m-sequence (characteristic polynomial x^8+x^6+x^5+x^4+1, period 255) at a programmable bit rate. It presents each symbol as a logic bit and as a slew-limited bipolar 12-bit DAC sample stream. It feeds the channel/noise-injection path whose far end is the receiver chain (downsampler, FIFO, noise reduction, bit recovery). It also serves as the bench stimulus source for that receiver.

## Interface
- DIV_W, 16, width of the bit-period divider input
- AMP, 12'sd1024, positive drive level; symbol 1 -> +AMP, symbol 0 -> -AMP (1 <= AMP <= 2047)
- STEP, 12'd64, max per-cycle change of dac_out (1 <= STEP <= 2*AMP)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes divider, LFSR, index and ramp
- load  in  1  synchronous seed load, one-cycle pulse
- seed  in  8  LFSR seed sampled on load; 8'h00 replaced by 8'h01
- div  in  DIV_W  bit period minus one, in clk cycles; 0 treated as 1
- bit_out  out  1  current transmitted symbol
- bit_strobe  out  1  one-cycle pulse when bit_out takes a new symbol
- frame_start  out  1  one-cycle pulse coincident with bit_strobe for symbol index 0
- dac_out  out  12  signed two's-complement sample toward the DAC

## Operation
- Registers:
  - lfsr[7:0]
  - cnt[DIV_W-1:0]
  - idx[7:0], symbol index 0..254
  - bit_out
  - dac_out
  - strobe and frame flags
- Reset (rst=0, asynchronous): lfsr=8'hFF, cnt=0, idx=0, bit_out=0, bit_strobe=0, frame_start=0, dac_out=0.
- Priority per cycle: load > en > hold.
- load=1: lfsr<=(seed==0 ? 8'h01 : seed), cnt<=0, idx<=0, bit_strobe<=0, frame_start<=0. bit_out and dac_out are held. Applies regardless of en.
- en=1, load=0:
  - If cnt < max(div,1): cnt<=cnt+1.
  - Else (symbol boundary), all in the same edge:
    - cnt<=0
    - bit_out<=lfsr[7]
    - lfsr<={lfsr[6:0], lfsr[7]^lfsr[3]^lfsr[2]^lfsr[1]}
    - bit_strobe<=1
    - frame_start<=(idx==0)
    - idx<=(idx==254 ? 0 : idx+1)
  - Symbol period is therefore max(div,1)+1 cycles.
- en=0, load=0: every register holds. bit_strobe and frame_start are forced 0.
- Ramp runs when en=1 or load=1 is not the case; it advances only when en=1:
  - target = bit_out ? +AMP : -AMP
  - diff = target - dac_out, computed at 13 bits signed
  - If |diff| <= STEP: dac_out<=target. Otherwise dac_out moves STEP toward target.
  - No overshoot; no wrap, since |dac_out| <= AMP <= 2047.
- The LFSR never reaches 8'h00: the seed is sanitised, and a nonzero state has no zero successor in a maximal-length sequence.
- div changes take effect on the next compare. If div is lowered below the current cnt, the boundary fires on the next en cycle because the compare is >=.

## Timing
- bit_strobe, frame_start and bit_out update on the same edge. bit_out is stable for the full symbol period after that.
- First strobe after reset or load occurs on the (max(div,1)+1)-th en-cycle.
- First symbol emitted after load = seed[7] (sanitised seed).
- frame_start recurs every 255 strobes. Its first occurrence is on the first strobe after reset or load.
- dac_out full-swing transition completes ceil(2*AMP/STEP) en-cycles after the bit_out change. With the defaults, 32 cycles.
- Symbol period must be >= ceil(2*AMP/STEP) cycles for a full swing. This is a system constraint; it is not checked.
- Reset mid-symbol: all outputs go to reset values immediately, without waiting for a clk edge.
- load coincident with a boundary: load wins; no strobe is produced.

## Test plan
- Reset, en=1, div=3:
  - strobes every 4 cycles, first on cycle 4
  - first 8 bit_out values = 1
  - over 255 strobes: 128 ones, 127 zeros, longest run of ones 8, of zeros 7
  - the 256th symbol equals the 1st
- load with seed=8'h00, then compare against seed=8'h01: the two runs give identical bit streams.
- frame_start pulses at strobes 1, 256 and 511, and never at any other strobe.
- Ramp, defaults, div=99: on a 0->1 bit change, dac_out goes -1024 -> +1024 in exactly 32 cycles, in steps of +64, with no overshoot. Then a 1-cycle check that it holds at +1024.
- en low for 10 cycles mid-symbol: cnt, lfsr, idx and dac_out all hold. No strobes occur during the gap. The symbol period is extended by exactly 10 cycles.
- Asynchronous rst pulse between clk edges mid-ramp: dac_out=0, bit_out=0 and bit_strobe=0 immediately. After release, the sequence restarts from 8'hFF with the first strobe after div+1 cycles.
